zero_cross_mul_pipe: RTL
========================

# zero_cross_mul_pipe

Parametrised, handshaked fixed-point multiplier for the zero_cross datapath. It is the successor to the fixed single-stage signed×unsigned multiplier. It adds:
- selectable operand signedness
- 1–4 pipeline stages
- a valid/ready flow control with global stall
- a post-multiply arithmetic right shift with rounding
- saturation, plus a sticky overflow flag

It sits between the coefficient/sample fetch logic and the accumulator, producing Q-format products.

## Interface
- din0_WIDTH, 32, operand A width
- din1_WIDTH, 34, operand B width
- dout_WIDTH, 32, result width
- NUM_STAGE, 2, pipeline depth (legal 1..4)
- DIN0_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned
- DIN1_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned
- SHIFT, 32, arithmetic right shift applied to the full product (0..din0_WIDTH+din1_WIDTH-1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ce  in  1  global clock enable; 0 freezes all state
- in_valid  in  1  din0/din1 valid
- in_ready  out  1  block accepts operands this cycle
- din0  in  din0_WIDTH  operand A
- din1  in  din1_WIDTH  operand B
- out_valid  out  1  dout valid
- out_ready  in  1  consumer accepts dout
- dout  out  dout_WIDTH  rounded, shifted, saturated (or wrapped) product
- ovf  out  1  sticky: an out-of-range result has left the block
- ovf_clr  in  1  synchronous clear of ovf

## Operation
- Each operand is extended by one bit according to its DINx_SIGNED. Product P is signed, din0_WIDTH+din1_WIDTH+2 bits wide, and exact.
- Rounding:
  - SHIFT>0: R = (P + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - SHIFT=0: R = P.
- Range check: R is in range if it fits in a signed dout_WIDTH field. Otherwise it is out of range (OOR).
- Output value: see Configuration. The computed result plus an OOR bit travel down a NUM_STAGE-deep pipeline, each stage with a valid bit. Implementation may retime the arithmetic across stages; only end-to-end behaviour is specified.
- Enable: en = ce && (!out_valid || out_ready). All stage registers and valid bits advance only when en=1.
- in_ready = en. A transfer occurs when in_valid && in_ready.
- Stage-1 valid loads in_valid && en. Bubbles propagate; they are not collapsed.
- Output transfer: out_valid && out_ready.
- ovf:
  - set on any output transfer whose OOR bit is 1
  - cleared when ovf_clr=1
  - simultaneous set and clear: set wins
  - ovf_clr is honoured regardless of ce
- Reset (reset=0, asynchronous, mid-operation included):
  - all valid bits, out_valid and ovf go to 0 immediately
  - dout goes to 0
  - in-flight data is discarded
  - in_ready follows ce after reset release

## Timing
- Latency: NUM_STAGE enabled cycles from input transfer to out_valid=1 with that result.
- Throughput: one result per cycle while out_ready=1 and ce=1.
- Stall: out_valid=1 && out_ready=0 drops in_ready combinationally in the same cycle. dout and out_valid hold stable until the transfer.
- ce=0: in_ready=0; outputs hold; no transfer is counted even if out_ready=1. ovf is still clearable.
- dout changes only on rising clk with en=1 or on reset assertion.
- Combinational paths: out_ready→in_ready and ce→in_ready. There is no in_valid→in_ready path.

## Configuration
- ZERO_CROSS_MUL_SAT_EN defined:
  - OOR results clamp to the signed maximum 2^(dout_WIDTH-1)-1 or minimum -2^(dout_WIDTH-1), chosen by the sign of R.
- ZERO_CROSS_MUL_SAT_EN undefined:
  - dout = R[dout_WIDTH-1:0] (wrap)
  - ovf and the OOR tracking are still generated

## Test plan
Defaults apply unless stated.
- Basic: din0=0x00010000, din1=0x1_00000000 → after 2 cycles dout=0x00010000, ovf=0.
- Rounding:
  - din0=3, din1=0x0_80000000 → dout=2.
  - din0=0xFFFFFFFD (-3), same din1 → dout=0xFFFFFFFF (-1).
- Overflow: din0=0x7FFFFFFF, din1=0x3_FFFFFFFF:
  - with macro → dout=0x7FFFFFFF, ovf=1 after transfer
  - without macro → dout=0xFFFFFFFC, ovf=1
  - ovf_clr pulsed in the same cycle as a second OOR transfer → ovf stays 1
- Backpressure:
  - stream 8 consecutive operands; hold out_ready=0 for cycles 3–6
  - → in_ready=0 during the stall, no loss or duplication, outputs in order, dout stable while stalled
- ce and reset:
  - ce=0 for 3 cycles mid-stream → state frozen
  - then assert reset with 2 results in flight → out_valid=0, ovf=0, dout=0 immediately
  - first post-reset result appears exactly NUM_STAGE cycles after its transfer
- Parameters: NUM_STAGE=1 and 4, DIN1_SIGNED=1, SHIFT=0, dout_WIDTH=66 → 1000 random vectors match the reference model, with latency exact.

Source files
------------

// File: rtl/zero_cross_mul_pipe_if.sv
// Handshake/data bundle for zero_cross_mul_pipe: operand channel, result channel and sticky overflow.
interface zero_cross_mul_pipe_if #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 34,
  parameter int dout_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  ovf;
  logic                  ovf_clr;

  modport master (
    output in_valid, din0, din1, out_ready, ovf_clr,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, out_ready, ovf_clr,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/zero_cross_mul_pipe.sv
// Handshaked fixed-point multiplier: exact product, round-half-up shift, range check, NUM_STAGE pipeline.
// Define ZERO_CROSS_MUL_SAT_EN to clamp out-of-range results; otherwise they wrap.
module zero_cross_mul_pipe #(
  parameter int din0_WIDTH  = 32,
  parameter int din1_WIDTH  = 34,
  parameter int dout_WIDTH  = 32,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  zero_cross_mul_pipe_if.slave   bus
);
  localparam int unsigned NS = NUM_STAGE;
  localparam int PW = din0_WIDTH + din1_WIDTH + 2;
  localparam int RW = PW + 1;
  localparam int EW = (RW > dout_WIDTH) ? RW : dout_WIDTH + 1;
  // 2^(SHIFT-1) for SHIFT>0, zero for SHIFT=0
  localparam logic [RW-1:0] RND = ({{(RW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
`ifdef ZERO_CROSS_MUL_SAT_EN
  localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
`endif

  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod;
  logic signed [RW-1:0]       rsum;
  logic signed [RW-1:0]       rshift;
  logic signed [EW-1:0]       r_ext;
  logic [dout_WIDTH-1:0]      res;
  logic                       oor;
  logic                       en;

  logic                  valid_q [NS];
  logic                  valid_d [NS];
  logic [dout_WIDTH-1:0] data_q  [NS];
  logic [dout_WIDTH-1:0] data_d  [NS];
  logic                  oor_q   [NS];
  logic                  oor_d   [NS];
  logic                  ovf_q;
  logic                  ovf_d;

  always_comb begin
    a_ext  = {(DIN0_SIGNED != 0) && bus.din0[din0_WIDTH-1], bus.din0};
    b_ext  = {(DIN1_SIGNED != 0) && bus.din1[din1_WIDTH-1], bus.din1};
    prod   = PW'(a_ext) * PW'(b_ext);
    rsum   = RW'(prod) + $signed(RND);
    rshift = rsum >>> SHIFT;
    r_ext  = EW'(rshift);
    // in range when every bit above the dout sign bit copies it
    oor    = (r_ext[EW-1:dout_WIDTH-1] != '0) && (r_ext[EW-1:dout_WIDTH-1] != '1);
`ifdef ZERO_CROSS_MUL_SAT_EN
    res    = oor ? (r_ext[EW-1] ? DMIN : DMAX) : r_ext[dout_WIDTH-1:0];
`else
    res    = r_ext[dout_WIDTH-1:0];
`endif
  end

  assign en = ce && (!valid_q[NS-1] || bus.out_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    oor_d   = oor_q;
    if (en) begin
      valid_d[0] = bus.in_valid;
      data_d[0]  = res;
      oor_d[0]   = oor;
      for (int unsigned i = 1; i < NS; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
        oor_d[i]   = oor_q[i-1];
      end
    end
  end

  // clear is independent of ce; a simultaneous out-of-range transfer overrides it
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (ce && valid_q[NS-1] && bus.out_ready && oor_q[NS-1]) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '{default: 1'b0};
      data_q  <= '{default: '0};
      oor_q   <= '{default: 1'b0};
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      oor_q   <= oor_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[NS-1];
  assign bus.dout      = data_q[NS-1];
  assign bus.ovf       = ovf_q;
endmodule
